mod_counter: RTL and testbench
==============================

// Module: mod_counter
// PURPOSE
//   Parametrised up/down modulo counter; next generation of the free-running 8-bit counter.
//   Adds width/modulus parameters, count enable, direction, parallel load and terminal-count pulse.
//   Used as a timebase/event counter feeding datapath and control blocks on the clk domain.
// PARAMETERS
//   WIDTH    8    counter/output width in bits; legal range 1..32
//   MODULUS  256  count range 0..MODULUS-1; legal range 2..2**WIDTH
//   PRESCALE 4    enable cycles per count step; legal range >=1; used only with COUNTER_PRESCALE_EN
// PORTS
//   clk       in   1      rising-edge clock; sole clock
//   res       in   1      synchronous reset, active-high
//   en        in   1      count enable; one step per enabled cycle (per PRESCALE cycles if prescaled)
//   dir       in   1      1 = count up, 0 = count down; sampled on each step cycle
//   load      in   1      parallel load strobe
//   load_val  in   WIDTH  value to load
//   y         out  WIDTH  registered count
//   tc        out  1      registered terminal-count pulse, one cycle per wrap
//   zero      out  1      combinational, (y == 0)
// BEHAVIOUR
//   - One clock; reset is synchronous and active-high: clk, res.
//   - Reset (res=1 at clk edge): y=0, tc=0, prescaler=0; zero=1 the following cycle.
//   - Priority per edge: res > load > en.
//   - load=1: y <= (load_val > MODULUS-1) ? MODULUS-1 : load_val (clamp); tc <= 0; prescaler <= 0.
//     en and dir are ignored in the load cycle.
//   - Step, up: y==MODULUS-1 -> y<=0, tc<=1; otherwise y<=y+1, tc<=0.
//   - Step, down: y==0 -> y<=MODULUS-1, tc<=1; otherwise y<=y-1, tc<=0.
//   - No step (en=0, or prescaler not at terminal): y holds; tc<=0.
//   - Latency: one cycle from enabled edge to new y; tc is high in the same cycle y shows the wrapped value.
//   - A dir change takes effect at the next step; no extra cycle, no glitch on y.
//   - Arithmetic: compare against MODULUS-1, never rely on natural 2**WIDTH overflow.
//     With MODULUS==2**WIDTH the results are identical to a plain wrap.
//   - y never leaves 0..MODULUS-1 after reset, including after a load.
//   - Reset mid-count or mid-prescale: all state cleared on that edge; no pending tc survives.
//   - Illegal parameters (MODULUS<2, MODULUS>2**WIDTH, PRESCALE<1) stop elaboration via a generate-time check.
// CONFIGURATION
//   COUNTER_PRESCALE_EN defined:
//     - Internal prescaler of width clog2(PRESCALE), minimum 1 bit.
//     - Increments on each en=1 cycle; wraps at PRESCALE-1.
//     - A step occurs only on an en=1 cycle with prescaler==PRESCALE-1.
//     - en=0 holds the prescaler; load/res clear it.
//     - PRESCALE=1 behaves as the unprescaled build.
//   COUNTER_PRESCALE_EN undefined:
//     - No prescaler logic; every en=1 cycle is a step; PRESCALE is ignored.
// TESTING
//   1. WIDTH=8, MODULUS=10: res=1 for 2 clk, then res=0, en=1, dir=1 for 12 clk
//      -> y=0,1..9,0,1,2; tc=1 only in the cycle y returns to 0.
//   2. MODULUS=10, y=0, en=1, dir=0 -> y=9 with tc=1, then 8,7; zero=1 only while y=0.
//   3. MODULUS=10, load=1, load_val=200 -> y=9 next cycle, tc=0.
//      Then load_val=5 together with en=1 -> y=5 (load wins over en).
//   4. y=7, en=1, assert res=1 for one cycle -> y=0, tc=0 next edge; counting resumes from 0, 1, ...
//   5. Toggle dir every cycle with en=1 starting at y=3 -> y=4,3,4,3; en=0 -> y holds, tc=0.
//   6. COUNTER_PRESCALE_EN, PRESCALE=4, en=1, dir=1: y advances once every 4 clk.
//      Drop en for 3 clk mid-period -> phase is preserved; load clears phase (next step 4 en cycles later).

Source files
------------

// File: rtl/mod_counter.sv
// rtl/mod_counter.sv - parametrised up/down modulo counter with load, terminal-count pulse and optional prescaler (COUNTER_PRESCALE_EN)
module mod_counter #(
  parameter int     WIDTH    = 8,
  parameter longint MODULUS  = 256,
  parameter int     PRESCALE = 4
) (
  input  logic             clk,
  input  logic             res,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] y,
  output logic             tc,
  output logic             zero
);

  // Reject illegal parameter sets at elaboration time.
  generate
    if (WIDTH < 1 || WIDTH > 32 || MODULUS < 2 ||
        MODULUS > (longint'(1) << WIDTH) || PRESCALE < 1) begin : g_bad_params
      $error("mod_counter: illegal WIDTH/MODULUS/PRESCALE");
    end
  endgenerate

  // Top of the count range; all wrap decisions compare against this, never against overflow.
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic step;

`ifdef COUNTER_PRESCALE_EN
  localparam int             PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]  PRE_MAX  = PW'(PRESCALE - 1);
  localparam logic [PW-1:0]  PRE_ONE  = PW'(1);

  logic [PW-1:0] pre;

  assign step = en && (pre == PRE_MAX);

  // Prescaler: advances on enabled cycles, wraps at PRESCALE-1, cleared by reset or load.
  always_ff @(posedge clk) begin
    if (res) begin
      pre <= '0;
    end else if (load) begin
      pre <= '0;
    end else if (en) begin
      pre <= (pre == PRE_MAX) ? '0 : pre + PRE_ONE;
    end
  end
`else
  assign step = en;
`endif

  // Count register and terminal-count pulse; priority is reset, then load, then step.
  always_ff @(posedge clk) begin
    if (res) begin
      y  <= '0;
      tc <= 1'b0;
    end else if (load) begin
      y  <= (load_val > MAX_VAL) ? MAX_VAL : load_val;
      tc <= 1'b0;
    end else if (step) begin
      if (dir) begin
        if (y == MAX_VAL) begin
          y  <= '0;
          tc <= 1'b1;
        end else begin
          y  <= y + ONE;
          tc <= 1'b0;
        end
      end else begin
        if (y == '0) begin
          y  <= MAX_VAL;
          tc <= 1'b1;
        end else begin
          y  <= y - ONE;
          tc <= 1'b0;
        end
      end
    end else begin
      tc <= 1'b0;
    end
  end

  assign zero = (y == '0);

endmodule

// File: tb/tb_mod_counter.sv
// tb/tb_mod_counter.sv - randomized self-checking bench for mod_counter against an arithmetic reference model
module tb_mod_counter;

  localparam int WIDTH    = 8;
  localparam int MOD      = 10;
  localparam int PRESCALE = 4;

  logic             clk = 1'b0;
  logic             res = 1'b1;
  logic             en = 1'b0;
  logic             dir = 1'b1;
  logic             load = 1'b0;
  logic [WIDTH-1:0] load_val = '0;
  logic [WIDTH-1:0] y;
  logic             tc;
  logic             zero;

  int checks = 0;
  int failures = 0;

  // reference model state
  int m_y = 0;
  int m_tc = 0;
  int m_pre = 0;

  mod_counter #(.WIDTH(WIDTH), .MODULUS(MOD), .PRESCALE(PRESCALE)) dut (
    .clk(clk), .res(res), .en(en), .dir(dir), .load(load),
    .load_val(load_val), .y(y), .tc(tc), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Apply one cycle of stimulus, advance the model, then compare all outputs.
  task automatic cycle(input logic r, input logic e, input logic d,
                       input logic l, input logic [WIDTH-1:0] lv);
    bit do_step;
    @(negedge clk);
    res = r; en = e; dir = d; load = l; load_val = lv;
    @(posedge clk);
    if (r) begin
      m_y = 0; m_tc = 0; m_pre = 0;
    end else if (l) begin
      m_y = (int'(lv) > MOD - 1) ? MOD - 1 : int'(lv);
      m_tc = 0; m_pre = 0;
    end else begin
`ifdef COUNTER_PRESCALE_EN
      do_step = 0;
      if (e) begin
        if (m_pre == PRESCALE - 1) begin
          do_step = 1;
          m_pre = 0;
        end else begin
          m_pre++;
        end
      end
`else
      do_step = e;
`endif
      m_tc = 0;
      if (do_step) begin
        if (d) begin
          m_tc = (m_y == MOD - 1) ? 1 : 0;
          m_y = (m_y + 1) % MOD;
        end else begin
          m_tc = (m_y == 0) ? 1 : 0;
          m_y = (m_y + MOD - 1) % MOD;
        end
      end
    end
    #1;
    chk("y", 32'(y), 32'(m_y));
    chk("tc", 32'(tc), 32'(m_tc));
    chk("zero", 32'(zero), (m_y == 0) ? 32'd1 : 32'd0);
  endtask

  initial begin
    // reset for two cycles
    cycle(1, 0, 1, 0, 0);
    cycle(1, 0, 1, 0, 0);
    chk("reset_y", 32'(y), 32'd0);
    chk("reset_zero", 32'(zero), 32'd1);

    // count up through a wrap
    for (int i = 0; i < 12 * PRESCALE; i++) cycle(0, 1, 1, 0, 0);

    // count down from 0 through a wrap
    cycle(1, 0, 1, 0, 0);
    for (int i = 0; i < 3 * PRESCALE; i++) cycle(0, 1, 0, 0, 0);

    // load clamps out-of-range values; load beats en
    cycle(0, 0, 1, 1, 8'd200);
    chk("load_clamp", 32'(y), 32'(MOD - 1));
    cycle(0, 1, 1, 1, 8'd5);
    chk("load_wins", 32'(y), 32'd5);
    cycle(0, 0, 1, 1, 8'd9);
    chk("load_top", 32'(y), 32'd9);

    // reset mid-count
    cycle(0, 0, 1, 1, 8'd7);
    cycle(1, 1, 1, 0, 0);
    chk("mid_reset", 32'(y), 32'd0);
    for (int i = 0; i < 2 * PRESCALE; i++) cycle(0, 1, 1, 0, 0);

    // toggle dir every cycle, then hold with en=0
    cycle(0, 0, 1, 1, 8'd3);
    for (int i = 0; i < 4 * PRESCALE; i++) cycle(0, 1, (i % 2) == 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, 0);

    // enable gaps mid-period, then load mid-period
    for (int i = 0; i < 2; i++) cycle(0, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, 0);
    for (int i = 0; i < 6; i++) cycle(0, 1, 1, 0, 0);
    cycle(0, 1, 1, 1, 8'd2);
    for (int i = 0; i < 6; i++) cycle(0, 1, 1, 0, 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic r, e, d, l;
      logic [WIDTH-1:0] lv;
      r  = ($urandom_range(0, 99) < 2);
      l  = ($urandom_range(0, 99) < 8);
      e  = ($urandom_range(0, 99) < 75);
      d  = ($urandom_range(0, 99) < 60);
      lv = ($urandom_range(0, 1) == 1) ? WIDTH'($urandom_range(0, MOD - 1)) : WIDTH'($urandom);
      cycle(r, e, d, l, lv);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
